reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port integer register file with write-to-read bypass, a per-register busy scoreboard and a sequential bulk-clear engine. It replaces the single-cycle core's two-read/one-write register file. The pipelined RV32I core uses it at decode (operand read and hazard check) and writeback.

## Interface
Parameters:
- XLEN, 32: data width.
- NREGS, 32: number of architectural registers. Power of two, at least 4. AW = $clog2(NREGS).
- NRD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 enables same-cycle write-to-read forwarding.
- ZERO_REG, 1: 1 makes entry 0 hardwired to zero.

Ports:
- clk  in  1: single clock, all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- raddr  in  NRD*AW: read addresses; port i is at [i*AW +: AW].
- rdata  out  NRD*XLEN: read data, combinational; port i is at [i*XLEN +: XLEN].
- rs_busy  out  NRD: port i's register has a pending write.
- reg_wr  in  1: write enable.
- waddr  in  AW: write address.
- wdata  in  XLEN: write data.
- issue_valid  in  1: an instruction producing issue_rd is issued this cycle.
- issue_rd  in  AW: destination register of the issued instruction.
- clr_req  in  1: request to sweep-clear all registers.
- clr_busy  out  1: sweep in progress.

## Operation
- State: NREGS×XLEN storage array, NREGS busy bits, a 2-state FSM (IDLE, SWEEP) and an AW-bit sweep pointer.
- Zero register: when ZERO_REG=1, entry 0 always reads 0, is never busy, and ignores writes and issues. A "write-qualified" address below means nonzero when ZERO_REG=1, and any address when ZERO_REG=0.
- Write: in IDLE, when reg_wr=1 and waddr is write-qualified, storage[waddr] takes wdata at the rising edge.
- Read, port i:
  - If BYPASS=1, FSM is IDLE, reg_wr=1, waddr==raddr_i and the address is write-qualified, rdata_i = wdata.
  - Otherwise rdata_i = storage[raddr_i].
- Scoreboard, in IDLE:
  - issue_valid with a write-qualified issue_rd sets busy[issue_rd].
  - A qualifying write clears busy[waddr].
  - Set and clear to the same register in one cycle: set wins (a new producer overrides).
- rs_busy_i:
  - In IDLE: busy[raddr_i], except it is 0 when the bypass condition for port i holds.
  - In SWEEP: 1 on all ports.
- Clear FSM:
  - IDLE → SWEEP on clr_req=1. The pointer loads 1 if ZERO_REG=1, else 0.
  - SWEEP: each cycle, storage[ptr] ← 0, busy[ptr] ← 0, then ptr increments.
  - SWEEP → IDLE in the cycle ptr==NREGS-1 is cleared.
  - In SWEEP, reg_wr, issue_valid and clr_req are ignored (dropped, not queued).
  - clr_busy = (FSM==SWEEP).
- Address arithmetic: the pointer is AW bits; the terminal compare is against NREGS-1, so there is no wrap-around.

## Timing
- Reset (rst_n=0, takes effect immediately, independent of clk):
  - Storage and busy bits clear to 0; FSM goes to IDLE; ptr clears to 0.
  - Outputs: clr_busy=0, rs_busy=0, rdata=0 for every address.
- Reset asserted mid-sweep aborts the sweep. After release the block is in IDLE with everything zeroed.
- Read latency is 0 cycles (combinational from raddr, wdata and state).
- Write latency: visible in storage 1 cycle after the write edge; visible same-cycle only via bypass.
- Busy set by issue in cycle N: rs_busy reflects it from cycle N+1.
- Sweep duration: NREGS-1 cycles when ZERO_REG=1, NREGS cycles when ZERO_REG=0.
  - clr_req seen at edge E: clr_busy is high from E through the edge that clears entry NREGS-1, and low in the following cycle.
- A clr_req arriving in the same cycle as reg_wr/issue_valid (FSM in IDLE): the write and the busy-set both take effect at that edge, and the sweep starts at that edge. The sweep then clears them.
- The core must not assert reg_wr or issue_valid while clr_busy=1; if it does, they are dropped.

## Test plan
- Reset then read: rst_n=0 mid-cycle, raddr ports = 5, 31 → rdata=0, rs_busy=0, clr_busy=0 immediately without a clock edge.
- Write/read and x0: write 0xDEADBEEF to x7, and 0x1234 to x0 → next cycle x7 reads 0xDEADBEEF, x0 reads 0. With BYPASS=1, reading x7 in the write cycle returns 0xDEADBEEF; with BYPASS=0 it returns the old value.
- Scoreboard: issue_rd=9 in cycle 0 → rs_busy=1 for x9 from cycle 1. Writeback to x9 in cycle 3 → rs_busy=0 in cycle 3 (BYPASS=1) and cycle 4 (BYPASS=0). Issue and write to x9 in the same cycle → busy stays 1.
- Sweep: fill x1..x31 with nonzero values and set busy on x4; pulse clr_req → clr_busy high for exactly 31 cycles, all rs_busy=1 during the sweep, afterwards all reads 0 and busy cleared. reg_wr during the sweep is dropped.
- Reset mid-sweep: rst_n=0 at sweep cycle 10 → clr_busy=0 at once. After release, state is IDLE and all reads return 0.
- Parameter sweep: NREGS=16, NRD=4, XLEN=64, ZERO_REG=0 → x0 is writable; sweep lasts 16 cycles; all four ports read independent addresses correctly.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus between the pipelined core (master) and the multi-port register file (slave).
// Read ports are packed: port i sits at raddr[i*AW +: AW] and rdata[i*XLEN +: XLEN].
interface reg_file_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   raddr;
   logic [NRD*XLEN-1:0] rdata;
   logic [NRD-1:0]      rs_busy;
   logic                reg_wr;
   logic [AW-1:0]       waddr;
   logic [XLEN-1:0]     wdata;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                clr_req;
   logic                clr_busy;

   modport master (
      output raddr, reg_wr, waddr, wdata, issue_valid, issue_rd, clr_req,
      input  rdata, rs_busy, clr_busy
   );

   modport slave (
      input  raddr, reg_wr, waddr, wdata, issue_valid, issue_rd, clr_req,
      output rdata, rs_busy, clr_busy
   );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass, per-register
// busy scoreboard and a one-entry-per-cycle bulk-clear sweep.
module reg_file_mp #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst_n,
   reg_file_mp_if.slave rf
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t           r_state, w_state_nxt;
   logic [AW-1:0]    r_ptr, w_ptr_nxt;
   logic [XLEN-1:0]  r_mem [NREGS];
   logic [NREGS-1:0] r_busy;

   logic             w_idle, w_wr_en, w_iss_en;
   logic [AW-1:0]    w_ra [NRD];
   logic [NRD-1:0]   w_byp;

   // Entry 0 is untouchable when it is the hardwired zero register.
   function automatic logic f_wr_qual(input logic [AW-1:0] a);
      return (ZERO_REG == 0) || (a != '0);
   endfunction

   assign w_idle      = (r_state == IDLE);
   assign w_wr_en     = w_idle && rf.reg_wr && f_wr_qual(rf.waddr);
   assign w_iss_en    = w_idle && rf.issue_valid && f_wr_qual(rf.issue_rd);
   assign rf.clr_busy = (r_state == SWEEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         IDLE: begin
            if (rf.clr_req) begin
               w_state_nxt = SWEEP;
               w_ptr_nxt   = (ZERO_REG != 0) ? AW'(1) : '0;
            end
         end
         SWEEP: begin
            if (r_ptr == AW'(NREGS - 1)) begin
               w_state_nxt = IDLE;
               w_ptr_nxt   = '0;
            end else begin
               w_ptr_nxt = r_ptr + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: the array is reset because reads must return zero right after reset;
   // that rules out a RAM macro and keeps it in flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      end else if (r_state == SWEEP) begin
         r_mem[r_ptr] <= '0;
      end else if (w_wr_en) begin
         r_mem[rf.waddr] <= rf.wdata;
      end
   end

   // NOTE: the issue set is written after the writeback clear, so the later
   // non-blocking assignment wins and a new producer overrides a retiring one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else if (r_state == SWEEP) begin
         r_busy[r_ptr] <= 1'b0;
      end else begin
         if (w_wr_en)  r_busy[rf.waddr]   <= 1'b0;
         if (w_iss_en) r_busy[rf.issue_rd] <= 1'b1;
      end
   end

   always_comb begin
      w_ra       = '{default: '0};
      w_byp      = '0;
      rf.rdata   = '0;
      rf.rs_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         w_ra[p]  = rf.raddr[p*AW +: AW];
         w_byp[p] = (BYPASS != 0) && w_wr_en && (rf.waddr == w_ra[p]);
         rf.rdata[p*XLEN +: XLEN] = w_byp[p] ? rf.wdata : r_mem[w_ra[p]];
         // During a sweep every operand is reported busy so decode stalls.
         rf.rs_busy[p] = !w_idle || (r_busy[w_ra[p]] && !w_byp[p]);
      end
   end
endmodule
